// File: rtl/gcn_coo_aggregator_if.sv
// Handshake and memory bus of the GCN COO aggregator.
// slave = aggregator side, master = controller / row and COO memory side.
interface gcn_coo_aggregator_if #(
  parameter int NUM_NODES      = 6,
  parameter int NUM_CLASSES    = 3,
  parameter int NUM_EDGES      = 6,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int NODE_BW        = $clog2(NUM_NODES),
  parameter int EDGE_BW        = $clog2(NUM_EDGES),
  parameter int CLASS_BW       = $clog2(NUM_CLASSES)
);
  logic                                  start;
  logic [EDGE_BW-1:0]                    coo_address;
  logic [2*NODE_BW-1:0]                  coo_in;
  logic [NODE_BW-1:0]                    row_address;
  logic                                  enable_read;
  logic [NUM_CLASSES*DOT_PROD_WIDTH-1:0] row_in;
  logic                                  busy;
  logic                                  done;
  logic [NUM_NODES*CLASS_BW-1:0]         max_addi_answer;
  logic                                  index_err;

  modport slave (
    input  start, coo_in, row_in,
    output coo_address, row_address, enable_read,
    output busy, done, max_addi_answer, index_err
  );

  modport master (
    output start, coo_in, row_in,
    input  coo_address, row_address, enable_read,
    input  busy, done, max_addi_answer, index_err
  );
endinterface

// File: rtl/gcn_coo_aggregator.sv
// GCN neighbour aggregation over a COO edge list, then per-node argmax.
// Optional macro GCN_AGG_SATURATE_EN: saturating accumulators (wrap otherwise).
module gcn_coo_aggregator #(
  parameter int NUM_NODES      = 6,
  parameter int NUM_CLASSES    = 3,
  parameter int NUM_EDGES      = 6,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ACC_WIDTH      = 18,
  parameter int NODE_BW        = $clog2(NUM_NODES),
  parameter int EDGE_BW        = $clog2(NUM_EDGES),
  parameter int CLASS_BW       = $clog2(NUM_CLASSES)
) (
  input  logic                 clk,
  input  logic                 reset,
  gcn_coo_aggregator_if.slave  bus
);
  localparam int CW = NODE_BW + 1;
  localparam int DW = DOT_PROD_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_EDGE_A, S_EDGE_B, S_ARGMAX, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EDGE_BW-1:0]   edge_q, edge_d;
  logic [ACC_WIDTH-1:0] agg_q [NUM_NODES][NUM_CLASSES];
  logic [NUM_NODES*CLASS_BW-1:0] ans_q;
  logic                 err_q;

  logic [NODE_BW-1:0]  src, dst, tgt, cnt_node;
  logic                bad_idx, last_node, last_edge, am_end;
  logic                run_start;
  logic [CLASS_BW-1:0] best;

  assign src       = bus.coo_in[2*NODE_BW-1 -: NODE_BW];
  assign dst       = bus.coo_in[NODE_BW-1:0];
  assign tgt       = (state_q == S_EDGE_A) ? dst : src;
  assign bad_idx   = (int'(src) >= NUM_NODES) ||
                     (int'(dst) >= NUM_NODES);
  assign cnt_node  = cnt_q[NODE_BW-1:0];
  assign last_node = (cnt_q == CW'(NUM_NODES - 1));
  assign am_end    = (cnt_q == CW'(NUM_NODES));
  assign last_edge = (edge_q == EDGE_BW'(NUM_EDGES - 1));
  assign run_start = bus.start &&
                     (state_q == S_IDLE || state_q == S_DONE);

  function automatic logic [ACC_WIDTH-1:0] acc_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [DW-1:0]        b
  );
`ifdef GCN_AGG_SATURATE_EN
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + (ACC_WIDTH+1)'(b);
    return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
`else
    return a + ACC_WIDTH'(b);
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_INIT;
      S_INIT:   if (last_node) state_d = S_EDGE_A;
      S_EDGE_A: state_d = S_EDGE_B;
      S_EDGE_B: state_d = last_edge ? S_ARGMAX : S_EDGE_A;
      S_ARGMAX: if (am_end) state_d = S_DONE;
      S_DONE:   if (bus.start) state_d = S_INIT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.enable_read = 1'b0;
    bus.coo_address = '0;
    bus.row_address = '0;
    case (state_q)
      S_INIT: begin
        bus.busy        = 1'b1;
        bus.enable_read = 1'b1;
        bus.row_address = cnt_node;
      end
      S_EDGE_A, S_EDGE_B: begin
        bus.busy        = 1'b1;
        bus.enable_read = 1'b1;
        bus.coo_address = edge_q;
        bus.row_address = (state_q == S_EDGE_A) ? src : dst;
      end
      S_ARGMAX: bus.busy = 1'b1;
      S_DONE:   bus.done = 1'b1;
      default:  ;
    endcase
  end

  assign bus.max_addi_answer = ans_q;
  assign bus.index_err       = err_q;

  // ARGMAX runs one extra drain cycle after the last node is written
  always_comb begin
    cnt_d  = '0;
    edge_d = edge_q;
    if ((state_q == S_INIT || state_q == S_ARGMAX) &&
        state_d == state_q)
      cnt_d = cnt_q + CW'(1);
    if (state_q == S_INIT)        edge_d = '0;
    else if (state_q == S_EDGE_B) edge_d = edge_q + EDGE_BW'(1);
  end

  // strict '>' keeps the lowest class index on ties
  always_comb begin
    best = '0;
    for (int k = 1; k < NUM_CLASSES; k++)
      if (agg_q[cnt_node][k] > agg_q[cnt_node][best])
        best = CLASS_BW'(k);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      edge_q <= '0;
      ans_q  <= '0;
      err_q  <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++)
        for (int k = 0; k < NUM_CLASSES; k++)
          agg_q[n][k] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      if (run_start) err_q <= 1'b0;
      case (state_q)
        S_INIT:
          for (int k = 0; k < NUM_CLASSES; k++)
            agg_q[cnt_node][k] <=
              ACC_WIDTH'(bus.row_in[k*DW +: DW]);
        S_EDGE_A, S_EDGE_B:
          if (bad_idx) err_q <= 1'b1;
          else if (src != dst)
            for (int k = 0; k < NUM_CLASSES; k++)
              agg_q[tgt][k] <= acc_add(agg_q[tgt][k],
                                       bus.row_in[k*DW +: DW]);
        S_ARGMAX:
          if (!am_end)
            ans_q[cnt_node*CLASS_BW +: CLASS_BW] <= best;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/gcn_coo_aggregator.md
Name: gcn_coo_aggregator

Overview:
Parametrised successor to the fixed 6-node GCN aggregation/argmax stage. It takes the FM×WM product rows from an external row memory and walks a COO edge list of configurable length. It sums each node's row with its neighbours' rows (undirected edges plus a self term), then produces a per-node argmax class index. It sits after the combination engine inside GCN and drives max_addi_answer/done toward the top level.

Parameters:
NUM_NODES, 6, nodes (rows of the FM×WM product)
NUM_CLASSES, 3, classes per row (WEIGHT_COLS)
NUM_EDGES, 6, COO columns processed per run
DOT_PROD_WIDTH, 16, unsigned width of each input row element
ACC_WIDTH, 18, unsigned accumulator width per element, must be >= DOT_PROD_WIDTH
NODE_BW, $clog2(NUM_NODES), COO node index width
EDGE_BW, $clog2(NUM_EDGES), COO address width
CLASS_BW, $clog2(NUM_CLASSES), argmax index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE or DONE
coo_address  out  EDGE_BW  edge index being fetched
coo_in  in  2×NODE_BW  {src,dst} for coo_address, valid same cycle
row_address  out  NODE_BW  FM×WM row being fetched
enable_read  out  1  row_address valid
row_in  in  NUM_CLASSES×DOT_PROD_WIDTH  row data for row_address, valid same cycle
busy  out  1  run in progress
done  out  1  results valid; held until next start or reset
max_addi_answer  out  NUM_NODES×CLASS_BW  per-node argmax, packed, node 0 at index 0
index_err  out  1  sticky: an edge referenced a node >= NUM_NODES during this run

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; accumulators 0.
- Memory model: coo_in and row_in are combinational responses to coo_address and row_address. Both are sampled on the next rising edge.
- State IDLE: wait for start=1, then go to INIT. Clear index_err.
- State INIT, NUM_NODES cycles, n=0..NUM_NODES-1: row_address=n, enable_read=1, agg[n] := row_in (self term).
- State EDGE_A, one cycle per edge e: coo_address=e, row_address=coo_in.src, agg[dst] += row_in.
- State EDGE_B, next cycle, same e: row_address=coo_in.dst, agg[src] += row_in. Then e++. After e=NUM_EDGES-1, go to ARGMAX.
- src==dst: both cycles are consumed and no accumulation occurs (no double self loop).
- src or dst >= NUM_NODES: both cycles are consumed, no accumulation occurs, and index_err is set.
- State ARGMAX, NUM_NODES cycles: max_addi_answer[n] = index of the largest agg[n][k]. Ties go to the lowest k. Compare is unsigned on ACC_WIDTH.
- State DONE: done=1, busy=0. start=1 restarts: done drops and busy rises on the same edge, and INIT begins.
- Latency: done rises exactly 2*NUM_NODES + 2*NUM_EDGES + 1 rising edges after the edge that samples start.
- busy=1 in INIT, EDGE_A, EDGE_B and ARGMAX.
- start while busy is ignored.
- enable_read=0 outside INIT, EDGE_A and EDGE_B.
- Zero-extend row_in from DOT_PROD_WIDTH to ACC_WIDTH before adding.
- max_addi_answer holds the previous result until the ARGMAX stage of a new run overwrites it.
- Reset asserted mid-run aborts immediately to IDLE with all outputs cleared.

Optional Feature:
Macro GCN_AGG_SATURATE_EN.
- Defined: accumulator adds saturate at 2^ACC_WIDTH-1.
- Undefined: adds wrap modulo 2^ACC_WIDTH.
- All other behaviour is identical.

Test Plan:
- Defaults. Rows all 0 except row2={1,9,3}. One edge (2,5); other edges (0,0). Result: max_addi_answer[2]=1, [5]=1, others 0. done exactly 25 cycles after start, index_err=0.
- Edge (1,7) with NUM_NODES=6, otherwise as above. Result: index_err=1 and no node changes versus the baseline run. The run still completes in 25 cycles.
- Ties: row0={4,4,2}, no valid edges. Result: max_addi_answer[0]=0. A row of {2,5,5} gives 1.
- ACC_WIDTH=16, rows 0 and 1 = {0xFFFF,0,1}, edge (0,1). With GCN_AGG_SATURATE_EN, agg[1][0]=0xFFFF and answer=0. Without it, the sum wraps to 0xFFFE and answer is still 0. Change row1 to {0x0002,0,1}: without the macro, agg[1][0] wraps to 0x0001 and answer=2 (0x0001 vs 0x0002). With the macro, answer=0.
- Pulse start mid-EDGE_A: no effect. Then assert reset at edge cycle 3: all outputs 0 immediately. A fresh start gives the correct result 25 cycles later.
- Back-to-back: start in DONE with changed rows. done falls on that edge and new results appear after 25 cycles. max_addi_answer keeps the old values until ARGMAX.
